// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, defaults and helpers for the writeback stage
package wb_arbiter_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int XLEN_DEFAULT     = 32;
  localparam int LQ_DEPTH_DEFAULT = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Which source drives the output register on the coming edge.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LOAD = 2'd2
  } wb_src_e;

  function automatic logic [31:0] zext_rd(input logic [REG_ADDR_W-1:0] rd);
    return {{(32-REG_ADDR_W){1'b0}}, rd};
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - small power-of-two FIFO holding returned {rd, data} load entries
module wb_load_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 37,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop in a full cycle does not free a slot for a push in that same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU results and load returns onto the register file port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT,
  parameter int XLEN     = XLEN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  wb_stall,
  input  logic                  lsu_issue,
  input  logic [REG_ADDR_W-1:0] lsu_issue_rd,
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic [REG_ADDR_W-1:0] dec_rd,
  output logic                  load_hazard,
  output logic                  wb_wen,
  output logic [31:0]           wb_wraddr,
  output logic [XLEN-1:0]       wb_wrdata
);

  localparam int EW = REG_ADDR_W + XLEN;
  localparam int CW = $clog2(LQ_DEPTH + 1);

  logic [EW-1:0]         lq_rdata;
  logic [CW-1:0]         lq_count;
  logic                  lq_full;
  logic                  lq_empty;
  logic                  lq_pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;
  wb_src_e               sel;

  logic [31:0] pend;
  logic [31:0] pend_set;
  logic [31:0] pend_clr;
  logic [31:0] pend_next;

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (EW)
  ) u_lq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lsu_valid),
    .wdata ({lsu_rd, lsu_data}),
    .pop   (lq_pop),
    .rdata (lq_rdata),
    .count (lq_count),
    .full  (lq_full),
    .empty (lq_empty)
  );

  assign head_rd   = lq_rdata[EW-1 -: REG_ADDR_W];
  assign head_data = lq_rdata[XLEN-1:0];
  assign lsu_ready = !lq_full;
  assign wb_stall  = alu_valid && (hold || lq_full);

  // A full queue outranks the ALU so the LSU can never be blocked indefinitely.
  always_comb begin
    sel = SRC_NONE;
    if (!hold) begin
      if (lq_full) begin
        sel = SRC_LOAD;
      end else if (alu_valid) begin
        sel = SRC_ALU;
      end else if (!lq_empty) begin
        sel = SRC_LOAD;
      end
    end
  end

  assign lq_pop = (sel == SRC_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_wen    <= 1'b0;
      wb_wraddr <= '0;
      wb_wrdata <= '0;
    end else if (!hold) begin
      case (sel)
        SRC_ALU: begin
          wb_wen <= (alu_rd != REG_ZERO);
          if (alu_rd != REG_ZERO) begin
            wb_wraddr <= zext_rd(alu_rd);
            wb_wrdata <= alu_data;
          end
        end
        SRC_LOAD: begin
          wb_wen <= (head_rd != REG_ZERO);
          if (head_rd != REG_ZERO) begin
            wb_wraddr <= zext_rd(head_rd);
            wb_wrdata <= head_data;
          end
        end
        default: wb_wen <= 1'b0;
      endcase
    end
  end

  // Set wins over clear so a re-issue to the register just written stays pending.
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (lsu_issue) begin
      pend_set[lsu_issue_rd] = 1'b1;
    end
    if (lq_pop) begin
      pend_clr[head_rd] = 1'b1;
    end
    pend_next    = (pend & ~pend_clr) | pend_set;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= pend_next;
    end
  end

  assign load_hazard = ((dec_rs1 != REG_ZERO) && pend[dec_rs1]) ||
                       ((dec_rs2 != REG_ZERO) && pend[dec_rs2]) ||
                       ((dec_rd  != REG_ZERO) && pend[dec_rd]);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    lq_count <= CW'(LQ_DEPTH));

  a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
    wb_wen |-> (wb_wraddr != 32'd0));

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;

  localparam int LQ = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        wb_stall;
  logic        lsu_issue;
  logic [4:0]  lsu_issue_rd;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic        load_hazard;
  logic        wb_wen;
  logic [31:0] wb_wraddr;
  logic [31:0] wb_wrdata;

  wb_arbiter #(.LQ_DEPTH(LQ), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold         (hold),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .wb_stall     (wb_stall),
    .lsu_issue    (lsu_issue),
    .lsu_issue_rd (lsu_issue_rd),
    .lsu_valid    (lsu_valid),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .lsu_ready    (lsu_ready),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .load_hazard  (load_hazard),
    .wb_wen       (wb_wen),
    .wb_wraddr    (wb_wraddr),
    .wb_wrdata    (wb_wrdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pend;
  logic        m_wen;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        last_stall;

  task automatic model_reset();
    q.delete();
    m_pend = '0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  function automatic logic pend_of(input logic [4:0] r);
    return (r != 5'd0) && m_pend[r];
  endfunction

  task automatic model_edge();
    ent_t e;
    bit   was_full;
    was_full = (q.size() == LQ);
    if (!hold) begin
      if (was_full || (!alu_valid && q.size() > 0)) begin
        e = q.pop_front();
        m_wen = (e.rd != 5'd0);
        if (e.rd != 5'd0) begin
          m_addr     = 32'(e.rd);
          m_data     = e.data;
          m_pend[e.rd] = 1'b0;
        end
      end else if (alu_valid) begin
        m_wen = (alu_rd != 5'd0);
        if (alu_rd != 5'd0) begin
          m_addr = 32'(alu_rd);
          m_data = alu_data;
        end
      end else begin
        m_wen = 1'b0;
      end
    end
    if (lsu_valid && !was_full) begin
      e.rd   = lsu_rd;
      e.data = lsu_data;
      q.push_back(e);
    end
    if (lsu_issue && lsu_issue_rd != 5'd0) begin
      m_pend[lsu_issue_rd] = 1'b1;
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge.
  initial begin
    model_reset();
    last_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("m_wen", wb_wen, m_wen);
      if (m_wen) begin
        chk("m_addr", wb_wraddr, m_addr);
        chk("m_data", wb_wrdata, m_data);
      end
      chk("m_ready", lsu_ready, q.size() < LQ);
      chk("m_stall", wb_stall, alu_valid && (hold || q.size() == LQ));
      chk("m_hazard", load_hazard, pend_of(dec_rs1) || pend_of(dec_rs2) || pend_of(dec_rd));
      last_stall = wb_stall;
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_edge();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  logic [4:0] infl[$];

  function automatic bit in_flight(input logic [4:0] r);
    foreach (infl[i]) if (infl[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_issue = 1'b0; lsu_issue_rd = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    #3;
    chk("rst_wen", wb_wen, 0);
    chk("rst_addr", wb_wraddr, 0);
    chk("rst_data", wb_wrdata, 0);
    chk("rst_ready", lsu_ready, 1);
    chk("rst_hazard", load_hazard, 0);
    tick(); tick();
    rst_n = 1'b1;

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    mid(); chk("alu_stall", wb_stall, 0);
    tick(); alu_valid = 1'b0;
    mid();
    chk("alu_wen", wb_wen, 1);
    chk("alu_addr", wb_wraddr, 5);
    chk("alu_data", wb_wrdata, 32'hDEADBEEF);
    tick(); mid(); chk("alu_wen_low", wb_wen, 0);

    // x0 drops
    tick();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1;
    mid(); chk("x0_stall", wb_stall, 0);
    tick(); alu_valid = 1'b0;
    mid(); chk("x0_alu_wen", wb_wen, 0);
    tick(); lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h2;
    tick(); lsu_valid = 1'b0;
    tick(); mid(); chk("x0_load_wen", wb_wen, 0);

    // Collision: ALU wins, load follows
    tick(); lsu_issue = 1'b1; lsu_issue_rd = 5'd7;
    tick(); lsu_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h55;
    tick(); alu_valid = 1'b0; lsu_valid = 1'b0;
    mid(); chk("col_addr1", wb_wraddr, 3); chk("col_wen1", wb_wen, 1);
    tick(); mid();
    chk("col_addr2", wb_wraddr, 7); chk("col_data2", wb_wrdata, 32'h55);
    tick(); mid(); chk("col_wen_low", wb_wen, 0);

    // Full FIFO outranks ALU
    tick(); lsu_issue = 1'b1; lsu_issue_rd = 5'd8;
    tick(); lsu_issue_rd = 5'd9;
    tick(); lsu_issue = 1'b0; hold = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88;
    tick(); lsu_rd = 5'd9; lsu_data = 32'h99;
    tick(); lsu_valid = 1'b0; hold = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    mid(); chk("full_ready", lsu_ready, 0); chk("full_stall", wb_stall, 1);
    tick(); mid();
    chk("full_addr8", wb_wraddr, 8); chk("full_data8", wb_wrdata, 32'h88);
    chk("full_ready_after", lsu_ready, 1); chk("full_stall_after", wb_stall, 0);
    tick(); alu_valid = 1'b0;
    mid(); chk("full_addr4", wb_wraddr, 4); chk("full_data4", wb_wrdata, 32'h44);
    tick(); mid(); chk("full_addr9", wb_wraddr, 9); chk("full_data9", wb_wrdata, 32'h99);
    tick(); mid(); chk("full_wen_low", wb_wen, 0);

    // Hazard tracking
    tick(); lsu_issue = 1'b1; lsu_issue_rd = 5'd10; dec_rs1 = 5'd10;
    tick(); lsu_issue = 1'b1; lsu_issue_rd = 5'd0;
    #1; chk("haz_rs1", load_hazard, 1);
    dec_rs1 = 5'd0; dec_rd = 5'd10;
    #1; chk("haz_rd", load_hazard, 1);
    tick(); lsu_issue = 1'b0;
    dec_rd = 5'd0; dec_rs2 = 5'd0;
    #1; chk("haz_x0", load_hazard, 0);
    dec_rs1 = 5'd10;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0A0;
    tick(); lsu_valid = 1'b0;
    mid(); chk("haz_queued", load_hazard, 1);
    tick(); mid();
    chk("haz_wr_addr", wb_wraddr, 10); chk("haz_wr_data", wb_wrdata, 32'hA0A0);
    chk("haz_cleared", load_hazard, 0);

    // Hold freezes the output and pop, push still accepted
    tick(); dec_rs1 = 5'd0; lsu_issue = 1'b1; lsu_issue_rd = 5'd13;
    tick(); lsu_issue = 1'b0; alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC12;
    tick(); alu_valid = 1'b0; hold = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD13;
    mid(); chk("hold_addr0", wb_wraddr, 12);
    tick(); lsu_valid = 1'b0; dec_rs1 = 5'd13;
    mid(); chk("hold_wen", wb_wen, 1); chk("hold_addr", wb_wraddr, 12);
    chk("hold_data", wb_wrdata, 32'hC12); chk("hold_haz", load_hazard, 1);
    tick(); mid(); chk("hold_addr2", wb_wraddr, 12);
    hold = 1'b0;
    tick(); mid();
    chk("hold_pop_addr", wb_wraddr, 13); chk("hold_pop_data", wb_wrdata, 32'hD13);
    chk("hold_pop_haz", load_hazard, 0);

    // Asynchronous reset mid-stream
    tick(); dec_rs1 = 5'd0; lsu_issue = 1'b1; lsu_issue_rd = 5'd14;
    tick(); lsu_issue = 1'b0; alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'hF;
    tick(); alu_valid = 1'b0; hold = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_data = 32'hE;
    tick(); lsu_valid = 1'b0; dec_rs1 = 5'd14;
    mid(); chk("pre_rst_wen", wb_wen, 1); chk("pre_rst_haz", load_hazard, 1);
    chk("pre_rst_ready", lsu_ready, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_wen", wb_wen, 0); chk("arst_addr", wb_wraddr, 0);
    chk("arst_ready", lsu_ready, 1); chk("arst_haz", load_hazard, 0);
    tick(); tick();
    rst_n = 1'b1; hold = 1'b0; dec_rs1 = 5'd0;

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!(alu_valid && last_stall)) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      hold = ($urandom_range(0, 7) == 0);
      lsu_valid = 1'b0;
      lsu_rd    = 5'($urandom_range(0, 31));
      lsu_data  = $urandom;
      if (infl.size() > 0 && $urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, infl.size() - 1);
        lsu_valid = 1'b1;
        lsu_rd    = infl[k];
        if (q.size() < LQ) infl.delete(k);
      end else if (q.size() < LQ && $urandom_range(0, 9) == 0) begin
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
      end
      lsu_issue    = 1'b0;
      lsu_issue_rd = 5'($urandom_range(1, 31));
      if (!hold && $urandom_range(0, 2) == 0 &&
          !m_pend[lsu_issue_rd] && !in_flight(lsu_issue_rd)) begin
        lsu_issue = 1'b1;
        infl.push_back(lsu_issue_rd);
      end
      dec_rs1 = 5'($urandom_range(0, 31));
      dec_rs2 = 5'($urandom_range(0, 31));
      dec_rd  = 5'($urandom_range(0, 31));
    end

    tick(); mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
